clkmux_switch_ctrl: RTL and testbench



---
 rtl/clksw_pkg.sv | 27 ++
 rtl/sync_tgl_det.sv | 27 ++
 rtl/clkmux_switch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_clkmux_switch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clksw_pkg.sv
// Shared definitions for the clock-mux switch controller: state encoding and
// a parameter-legality check evaluated at elaboration.
package clksw_pkg;

  localparam logic [1:0] StIdleEnc   = 2'd0;
  localparam logic [1:0] StSettleEnc = 2'd1;
  localparam logic [1:0] StAbortEnc  = 2'd2;
  localparam logic [1:0] StDoneEnc   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = StIdleEnc,
    StSettle = StSettleEnc,
    StAbort  = StAbortEnc,
    StDone   = StDoneEnc
  } clksw_state_e;

  // The down-counter must be able to hold both load values.
  function automatic bit clksw_params_ok(int unsigned settle, int unsigned wdog,
                                         int unsigned cnt_w);
    longint unsigned cnt_lim;
    if (cnt_w < 1 || cnt_w > 32) return 1'b0;
    cnt_lim = 64'd1 << cnt_w;
    return (settle >= 1) && (wdog > settle) && (64'(settle) < cnt_lim) &&
           (64'(wdog) < cnt_lim);
  endfunction

endpackage

// File: rtl/sync_tgl_det.sv
// Two-flop synchroniser for an asynchronous divide-by-2 toggle, followed by
// a transition detector: edge_o pulses once per toggle of tgl_i.
module sync_tgl_det (
  input  logic clk,
  input  logic reset_n,
  input  logic tgl_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= tgl_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Either transition of the toggle corresponds to one source-clock edge.
  assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/clkmux_switch_ctrl.sv
// Request/settle controller driving the select input of a glitch-free clock mux.
// Define CLKMUX_SWITCH_CLKMON_EN to enable target-clock monitoring with watchdog abort.
module clkmux_switch_ctrl
  import clksw_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES   = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic select_o,
  output logic cur_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  input  logic err_clr_i,
  input  logic clk0_tgl_i,
  input  logic clk1_tgl_i
);

  localparam bit ParamsOk = clksw_params_ok(SETTLE_CYCLES, WDOG_CYCLES, CNT_W);

  if (!ParamsOk) begin : g_param_check
    $error("clkmux_switch_ctrl: illegal SETTLE_CYCLES/WDOG_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  clksw_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             select_q, cur_sel_q, busy_q, done_q, ready_q;
  logic             accept, cnt_zero, settle_ok;

  assign accept   = req_valid_i & ready_q;
  assign cnt_zero = (cnt_q == '0);

`ifdef CLKMUX_SWITCH_CLKMON_EN
  localparam logic [CNT_W-1:0] WdogLoad = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_q;
  logic             seen_q, err_q;
  logic             edge0, edge1, tgt_edge, seen, wdog_expired, abort_go;

  sync_tgl_det u_det0 (
    .clk     (clk),
    .reset_n (reset_n),
    .tgl_i   (clk0_tgl_i),
    .edge_o  (edge0)
  );

  sync_tgl_det u_det1 (
    .clk     (clk),
    .reset_n (reset_n),
    .tgl_i   (clk1_tgl_i),
    .edge_o  (edge1)
  );

  // select_q already holds the target source while in SETTLE.
  assign tgt_edge     = select_q ? edge1 : edge0;
  assign seen         = seen_q | tgt_edge;
  assign settle_ok    = cnt_zero & seen;
  assign wdog_expired = (wdog_q == '0) & ~seen;
  assign abort_go     = (state_q == StSettle) & ~settle_ok & wdog_expired;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_q <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (wdog_q != '0) wdog_q <= wdog_q - CNT_W'(1);
      if (state_q == StSettle && tgt_edge) seen_q <= 1'b1;
      if (accept) begin
        wdog_q <= WdogLoad;
        seen_q <= 1'b0;
      end
      if (err_clr_i) err_q <= 1'b0;
      if (abort_go) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk0_tgl_i, clk1_tgl_i, err_clr_i};
  assign settle_ok     = cnt_zero;
  assign err_o         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      select_q  <= 1'b0;
      cur_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (!cnt_zero) cnt_q <= cnt_q - CNT_W'(1);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (req_sel_i == cur_sel_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StSettle;
              select_q <= req_sel_i;
              cnt_q    <= SettleLoad;
            end
          end
        end
        StSettle: begin
          if (settle_ok) begin
            cur_sel_q <= select_q;
            state_q   <= StDone;
            done_q    <= 1'b1;
          end
`ifdef CLKMUX_SWITCH_CLKMON_EN
          else if (wdog_expired) begin
            // Fall back to the last good source and let the mux settle again.
            state_q  <= StAbort;
            select_q <= cur_sel_q;
            cnt_q    <= SettleLoad;
          end
`endif
        end
`ifdef CLKMUX_SWITCH_CLKMON_EN
        StAbort: begin
          if (cnt_zero) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign select_o    = select_q;
  assign cur_sel_o   = cur_sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_clkmux_switch_ctrl.sv
// Directed bench for clkmux_switch_ctrl (SETTLE_CYCLES=16, WDOG_CYCLES=64).
// Monitor scenarios run only when CLKMUX_SWITCH_CLKMON_EN is defined.
module tb_clkmux_switch_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic err_clr = 1'b0;
  logic clk0_tgl = 1'b0;
  logic clk1_tgl = 1'b0;
  logic tgl_run = 1'b1;
  logic req_ready, select, cur_sel, busy, done, err;
  int   n_pass = 0;
  int   n_total = 0;

  clkmux_switch_ctrl #(
    .SETTLE_CYCLES (16),
    .WDOG_CYCLES   (64),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid),
    .req_sel_i   (req_sel),
    .req_ready_o (req_ready),
    .select_o    (select),
    .cur_sel_o   (cur_sel),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_clr_i   (err_clr),
    .clk0_tgl_i  (clk0_tgl),
    .clk1_tgl_i  (clk1_tgl)
  );

  always #5 clk = ~clk;

  // Free-running source toggles so monitored builds see live clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #2;
      if (tgl_run) begin
        clk0_tgl = ~clk0_tgl;
        clk1_tgl = ~clk1_tgl;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_total++; if (select !== 1'b0) $display("FAIL reset_select: got %b want 0", select); else n_pass++;
    n_total++; if (cur_sel !== 1'b0) $display("FAIL reset_cur_sel: got %b want 0", cur_sel); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_same_sel();
    req_valid = 1'b1;
    req_sel   = 1'b0;
    step();  // N+1
    req_valid = 1'b0;
    n_total++; if (done !== 1'b1) $display("FAIL same_done_n1: got %b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL same_busy_n1: got %b want 1", busy); else n_pass++;
    n_total++; if (select !== 1'b0) $display("FAIL same_select_n1: got %b want 0", select); else n_pass++;
    step();  // N+2
    n_total++; if (done !== 1'b0) $display("FAIL same_done_n2: got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL same_busy_n2: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL same_ready_n2: got %b want 1", req_ready); else n_pass++;
    n_total++; if (select !== 1'b0) $display("FAIL same_select_n2: got %b want 0", select); else n_pass++;
  endtask

  task automatic test_switch();
    req_valid = 1'b1;
    req_sel   = 1'b1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL sw_ready_n: got %b want 1", req_ready); else n_pass++;
    step();  // N+1
    req_valid = 1'b0;
    n_total++; if (select !== 1'b1) $display("FAIL sw_select_n1: got %b want 1", select); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sw_busy_n1: got %b want 1", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL sw_done_n1: got %b want 0", done); else n_pass++;
    for (int c = 2; c <= 16; c++) begin
      step();
      n_total++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL sw_settle_c%0d: got busy=%b done=%b want busy=1 done=0", c, busy, done);
      else n_pass++;
    end
    step();  // N+17
    n_total++; if (done !== 1'b1) $display("FAIL sw_done_n17: got %b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sw_busy_n17: got %b want 1", busy); else n_pass++;
    step();  // N+18
    n_total++; if (done !== 1'b0) $display("FAIL sw_done_n18: got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL sw_busy_n18: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL sw_ready_n18: got %b want 1", req_ready); else n_pass++;
    n_total++; if (cur_sel !== 1'b1) $display("FAIL sw_cur_sel_n18: got %b want 1", cur_sel); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();  // N+1
    req_valid = 1'b0;
    repeat (4) step();  // N+5
    reset_n = 1'b0;
    step();  // N+6
    n_total++; if (select !== 1'b0) $display("FAIL mid_select: got %b want 0", select); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else n_pass++;
    n_total++; if (cur_sel !== 1'b0) $display("FAIL mid_cur_sel: got %b want 0", cur_sel); else n_pass++;
    reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", saw_done); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit saw_done = 1'b0;
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();  // N+1
    req_sel = 1'b0;
    n_total++; if (select !== 1'b1) $display("FAIL b2b_select_n1: got %b want 1", select); else n_pass++;
    for (int c = 2; c <= 17; c++) begin
      step();
      n_total++;
      if (select !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL b2b_hold_c%0d: got select=%b ready=%b want select=1 ready=0", c, select,
                 req_ready);
      else n_pass++;
    end
    step();  // N+18: first IDLE cycle
    n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_n18: got %b want 1", req_ready); else n_pass++;
    n_total++; if (select !== 1'b1) $display("FAIL b2b_select_n18: got %b want 1", select); else n_pass++;
    step();  // N+19
    req_valid = 1'b0;
    n_total++; if (select !== 1'b0) $display("FAIL b2b_select_n19: got %b want 0", select); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_n19: got %b want 1", busy); else n_pass++;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b1) $display("FAIL b2b_done_seen: got %b want 1", saw_done); else n_pass++;
    step();
    n_total++; if (cur_sel !== 1'b0) $display("FAIL b2b_cur_sel: got %b want 0", cur_sel); else n_pass++;
  endtask

`ifdef CLKMUX_SWITCH_CLKMON_EN
  task automatic test_wdog_abort();
    tgl_run = 1'b0;
    repeat (10) step();
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();  // N+1
    req_valid = 1'b0;
    repeat (63) step();  // N+64
    n_total++; if (select !== 1'b1) $display("FAIL wd_select_n64: got %b want 1", select); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wd_err_n64: got %b want 0", err); else n_pass++;
    step();  // N+65
    n_total++; if (select !== 1'b0) $display("FAIL wd_select_n65: got %b want 0", select); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL wd_err_n65: got %b want 1", err); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL wd_busy_n65: got %b want 1", busy); else n_pass++;
    repeat (15) step();  // N+80
    n_total++; if (done !== 1'b0) $display("FAIL wd_done_n80: got %b want 0", done); else n_pass++;
    step();  // N+81
    n_total++; if (done !== 1'b1) $display("FAIL wd_done_n81: got %b want 1", done); else n_pass++;
    n_total++; if (cur_sel !== 1'b0) $display("FAIL wd_cur_sel_n81: got %b want 0", cur_sel); else n_pass++;
    step();  // N+82
    n_total++; if (req_ready !== 1'b1) $display("FAIL wd_ready_n82: got %b want 1", req_ready); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL wd_err_sticky: got %b want 1", err); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_total++; if (err !== 1'b0) $display("FAIL wd_err_clr: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_late_edge();
    int  cyc = 1;
    bit  saw_done = 1'b0;
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();  // N+1
    req_valid = 1'b0;
    while (cyc < 30) begin
      step();
      cyc++;
    end
    clk1_tgl = ~clk1_tgl;  // first target edge in cycle N+30
    for (int c = 0; c < 20 && !saw_done; c++) begin
      step();
      cyc++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b1) $display("FAIL edge_done_seen: got %b want 1", saw_done); else n_pass++;
    n_total++;
    if (cyc < 31 || cyc > 36) $display("FAIL edge_done_cycle: got N+%0d want N+31..N+36", cyc);
    else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL edge_err: got %b want 0", err); else n_pass++;
    step();
    n_total++; if (cur_sel !== 1'b1) $display("FAIL edge_cur_sel: got %b want 1", cur_sel); else n_pass++;
    n_total++; if (select !== 1'b1) $display("FAIL edge_select: got %b want 1", select); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_same_sel();
    test_switch();
    test_reset_mid();
    test_back_to_back();
`ifdef CLKMUX_SWITCH_CLKMON_EN
    test_wdog_abort();
    test_late_edge();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
